// File: rtl/decode_alloc_rat_ckpt_tracker.sv
// RAT checkpoint tracker for decode/allocate: per-slot valid/tag/age, occupancy back-pressure,
// and selective or full flush on branch-commit-override with a registered recovery pointer.
module decode_alloc_rat_ckpt_tracker #(
  parameter int CKPT_COUNT       = 4,
  parameter int BID_WIDTH        = 4,
  parameter int READYN_THRESHOLD = 1,
  parameter int BCO_SELECTIVE    = 1,
  localparam int IDX_W           = $clog2(CKPT_COUNT),
  localparam int CNT_W           = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  snoop_hit,
  input  logic                  en_alloc,
  input  logic                  bp_valid,
  input  logic [BID_WIDTH-1:0]  bp_bid,
  input  logic                  bco_valid,
  input  logic [BID_WIDTH-1:0]  bco_bid,
  input  logic                  bc_valid,
  input  logic [BID_WIDTH-1:0]  bc_bid,
  output logic                  readyn,
  output logic [CKPT_COUNT-1:0] ckpt_valid,
  output logic [CNT_W-1:0]      ckpt_count,
  output logic                  rcv_valid,
  output logic                  rcv_hit,
  output logic [IDX_W-1:0]      rcv_idx,
  output logic                  err_overwrite
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(READYN_THRESHOLD);

  logic [CKPT_COUNT-1:0] valid_q, valid_n;
  logic [BID_WIDTH-1:0]  tag_q [CKPT_COUNT];
  logic [BID_WIDTH-1:0]  tag_n [CKPT_COUNT];
  // age_q[i][j] = 1: slot i was allocated before slot j (diagonal unused)
  logic [CKPT_COUNT-1:0] age_q [CKPT_COUNT];
  logic [CKPT_COUNT-1:0] age_n [CKPT_COUNT];
  logic                  rcv_valid_q, rcv_valid_n;
  logic                  rcv_hit_q, rcv_hit_n;
  logic [IDX_W-1:0]      rcv_idx_q, rcv_idx_n;
  logic                  err_q, err_n;

  logic [IDX_W-1:0] alloc_slot, bc_slot, bco_slot;
  logic             alloc, bc_hit, bco_hit;

  assign alloc_slot = bp_bid[IDX_W-1:0];
  assign bc_slot    = bc_bid[IDX_W-1:0];
  assign bco_slot   = bco_bid[IDX_W-1:0];
  assign alloc      = en_alloc & bp_valid;
  assign bc_hit     = bc_valid & valid_q[bc_slot] & (tag_q[bc_slot] == bc_bid);
  assign bco_hit    = valid_q[bco_slot] & (tag_q[bco_slot] == bco_bid);

  always_comb begin
    valid_n     = valid_q;
    tag_n       = tag_q;
    age_n       = age_q;
    rcv_valid_n = 1'b0;
    rcv_hit_n   = rcv_hit_q;
    rcv_idx_n   = rcv_idx_q;
    err_n       = err_q;
    if (snoop_hit) begin
      valid_n = '0;
    end else if (bco_valid) begin
      rcv_valid_n = 1'b1;
      rcv_hit_n   = bco_hit;
      rcv_idx_n   = bco_slot;
      if (BCO_SELECTIVE != 0 && bco_hit) begin
        valid_n[bco_slot] = 1'b0;
        for (int j = 0; j < CKPT_COUNT; j++) begin
          if (age_q[bco_slot][j]) valid_n[j] = 1'b0;
        end
      end else begin
        valid_n = '0;
      end
    end else begin
      if (bc_hit) valid_n[bc_slot] = 1'b0;
      if (alloc) begin
        // a same-cycle commit of this slot frees it first, so that is not an overwrite
        if (valid_q[alloc_slot] && !(bc_hit && bc_slot == alloc_slot)) err_n = 1'b1;
        for (int j = 0; j < CKPT_COUNT; j++) begin
          if (valid_n[j] && IDX_W'(j) != alloc_slot) age_n[j][alloc_slot] = 1'b1;
        end
        age_n[alloc_slot]   = '0;
        valid_n[alloc_slot] = 1'b1;
        tag_n[alloc_slot]   = bp_bid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      rcv_valid_q <= 1'b0;
      rcv_hit_q   <= 1'b0;
      rcv_idx_q   <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < CKPT_COUNT; i++) begin
        tag_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_n;
      rcv_valid_q <= rcv_valid_n;
      rcv_hit_q   <= rcv_hit_n;
      rcv_idx_q   <= rcv_idx_n;
      err_q       <= err_n;
      for (int i = 0; i < CKPT_COUNT; i++) begin
        tag_q[i] <= tag_n[i];
        age_q[i] <= age_n[i];
      end
    end
  end

  always_comb begin
    ckpt_count = '0;
    for (int i = 0; i < CKPT_COUNT; i++) ckpt_count = ckpt_count + CNT_W'(valid_q[i]);
  end

  assign readyn        = (ckpt_count >= THRESH);
  assign ckpt_valid    = valid_q;
  assign rcv_valid     = rcv_valid_q;
  assign rcv_hit       = rcv_hit_q;
  assign rcv_idx       = rcv_idx_q;
  assign err_overwrite = err_q;

endmodule
